sqrt_arbiter_ctrl: RTL and testbench

Controller and two-port arbiter for the iterative square-root datapath (`sqrt_DP`). It accepts operands from two requesters and grants the single datapath round-robin. It sequences the datapath's `ld`, `mux_select` and `ld_out` controls from load, through the 4-bit-per-cycle iterations, to output capture, and returns the result with a per-requester done pulse. A watchdog bounds the iteration count and flags runaway operations.

---
 rtl/sqrt_arbiter_ctrl.sv | 85 ++++++++
 tb/tb_sqrt_arbiter_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/sqrt_arbiter_ctrl.sv
// sqrt_arbiter_ctrl: round-robin two-port front end and sequencer for the iterative sqrt datapath
//   clk, rst (sync, active-low)
//   req0/req1, num0/num1 -> ack0/ack1, done0/done1, result, err   requester side
//   busy                                                          high outside IDLE
//   dp_in_num, dp_ld, dp_ld_out, dp_mux_select <- dp_finished, dp_res   datapath side
module sqrt_arbiter_ctrl #(
  parameter int SIZE = 32,
  parameter int MAX_ITER = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0,
  input  logic            req1,
  input  logic [SIZE-1:0] num0,
  input  logic [SIZE-1:0] num1,
  output logic            ack0,
  output logic            ack1,
  output logic            done0,
  output logic            done1,
  output logic [SIZE-1:0] result,
  output logic            err,
  output logic            busy,
  output logic [SIZE-1:0] dp_in_num,
  output logic            dp_ld,
  output logic            dp_ld_out,
  output logic            dp_mux_select,
  input  logic            dp_finished,
  input  logic [SIZE-1:0] dp_res
);
  localparam int CW = $clog2(MAX_ITER) + 1;
  typedef enum logic [2:0] {IDLE, LOAD, CALC, STORE, DONE} state_t;
  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic            ptr, owner, err_flag;
  logic [SIZE-1:0] op_reg;
  logic            grant1, timeout;
  // ptr holds the last-served port; on contention the other port wins
  assign grant1  = req1 & (~req0 | ~ptr);
  assign timeout = cnt == CW'(MAX_ITER - 1);
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= 1'b1;
      op_reg   <= '0;
      owner    <= 1'b0;
      err_flag <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && (req0 | req1)) begin
        op_reg <= grant1 ? num1 : num0;
        owner  <= grant1;
        ptr    <= grant1;
      end
      if (state == LOAD) cnt <= '0;
      if (state == CALC) begin
        cnt <= cnt + 1'b1;
        if (dp_finished | timeout) err_flag <= ~dp_finished;
      end
    end
  end
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = (req0 | req1) ? LOAD : IDLE;
      LOAD:    state_nx = CALC;
      CALC:    state_nx = (dp_finished | timeout) ? STORE : CALC;
      STORE:   state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    busy          = state != IDLE;
    ack0          = state == LOAD & ~owner;
    ack1          = state == LOAD & owner;
    done0         = state == DONE & ~owner;
    done1         = state == DONE & owner;
    err           = state == DONE & err_flag;
    result        = dp_res;
    dp_in_num     = op_reg;
    dp_mux_select = state == LOAD;
    dp_ld         = state == LOAD | state == CALC;
    dp_ld_out     = state == STORE;
  end
endmodule

// File: tb/tb_sqrt_arbiter_ctrl.sv
// tb_sqrt_arbiter_ctrl: directed bench for sqrt_arbiter_ctrl with a behavioural datapath model
module tb_sqrt_arbiter_ctrl;
  logic        clk = 0, rst = 0, req0 = 0, req1 = 0;
  logic [31:0] num0 = 0, num1 = 0;
  logic        ack0, ack1, done0, done1, err, busy, dp_ld, dp_ld_out, dp_mux_select, dp_finished;
  logic [31:0] result, dp_in_num;
  logic [31:0] dp_res = 32'hA5A5_0001;
  logic [31:0] lat_num = 0;
  logic [3:0]  cc = 0;
  logic        stuck = 0;
  int          total = 0, bad = 0;

  always #5 clk = ~clk;

  sqrt_arbiter_ctrl #(.SIZE(32), .MAX_ITER(5)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .num0(num0), .num1(num1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1), .result(result),
    .err(err), .busy(busy), .dp_in_num(dp_in_num), .dp_ld(dp_ld),
    .dp_ld_out(dp_ld_out), .dp_mux_select(dp_mux_select),
    .dp_finished(dp_finished), .dp_res(dp_res)
  );

  function automatic logic [31:0] isqrt(logic [31:0] x);
    logic [63:0] r = 0;
    for (int b = 15; b >= 0; b--) begin
      logic [63:0] t = r | (64'd1 << b);
      if (t * t <= {32'd0, x}) r = t;
    end
    return r[31:0];
  endfunction

  // datapath yields 4 result bits (8 operand bits) per iteration, at least one iteration
  function automatic int need(logic [31:0] x);
    int b = 0;
    for (int i = 0; i < 32; i++) if (x[i]) b = i + 1;
    return (b == 0) ? 1 : (b + 7) / 8;
  endfunction

  assign dp_finished = !stuck && (int'(cc) + 1 >= need(lat_num));

  always @(posedge clk) begin
    if (dp_ld && dp_mux_select) begin
      lat_num <= dp_in_num;
      cc <= 0;
    end else if (dp_ld) cc <= cc + 1;
    if (dp_ld_out) dp_res <= isqrt(lat_num);
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("exclusive", ((ack0 | ack1) & (done0 | done1)) | (ack0 & ack1) | (done0 & done1) | (err & ~(done0 | done1)), 0);
  endtask

  task automatic get_ack(string tag, int exp_n, logic exp_who, logic [31:0] exp_num);
    int n = 0;
    do begin step(); n++; end while (!(ack0 | ack1) && n < 30);
    chk({tag, "_ack_lat"}, n, exp_n);
    chk({tag, "_ack_who"}, {ack1, ack0}, exp_who ? 2'b10 : 2'b01);
    chk({tag, "_in_num"}, dp_in_num, exp_num);
    chk({tag, "_load_ctl"}, {busy, dp_ld, dp_mux_select, dp_ld_out}, 4'b1110);
    if (ack0) req0 = 0;
    if (ack1) req1 = 0;
  endtask

  task automatic get_done(string tag, int exp_k, logic exp_who, logic [31:0] exp_res, logic exp_err, int raise_at);
    int n = 0, calc = 0, early = 0;
    logic was_store = 0;
    do begin
      was_store = dp_ld_out;
      step();
      n++;
      if (n == raise_at) begin req1 = 1; num1 = 144; end
      if (dp_ld && !dp_mux_select) calc++;
      if (ack0 | ack1) early++;
    end while (!(done0 | done1) && n < 30);
    chk({tag, "_grant_to_done"}, n + 1, exp_k + 3);
    chk({tag, "_calc_cycles"}, calc, exp_k);
    chk({tag, "_ack_during_op"}, early, 0);
    chk({tag, "_store_before_done"}, was_store, 1);
    chk({tag, "_done_who"}, {done1, done0}, exp_who ? 2'b10 : 2'b01);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_err"}, err, exp_err);
  endtask

  initial begin
    step();
    step();
    chk("rst_outputs", {ack0, ack1, done0, done1, err, busy, dp_ld, dp_ld_out, dp_mux_select}, 0);
    chk("rst_in_num", dp_in_num, 0);
    chk("rst_result_follows", result, 32'hA5A5_0001);
    rst = 1;
    req0 = 1; num0 = 144;
    get_ack("single", 1, 0, 144);
    get_done("single", 1, 0, 12, 0, 0);
    step();
    chk("single_busy_low", busy, 0);
    req1 = 1; num1 = 0;
    get_ack("zero", 1, 1, 0);
    get_done("zero", 1, 1, 0, 0, 0);
    repeat (2) begin
      req0 = 1; req1 = 1; num0 = 32'hFFFF_FFFF; num1 = 81;
      get_ack("pair_a", 2, 0, 32'hFFFF_FFFF);
      get_done("pair_a", 4, 0, 65535, 0, 0);
      get_ack("pair_b", 2, 1, 81);
      get_done("pair_b", 1, 1, 9, 0, 0);
    end
    stuck = 1; req0 = 1; num0 = 144;
    get_ack("wdog", 2, 0, 144);
    get_done("wdog", 5, 0, 12, 1, 0);
    stuck = 0; req0 = 1; num0 = 81;
    get_ack("wdog_next", 2, 0, 81);
    get_done("wdog_next", 1, 0, 9, 0, 0);
    req0 = 1; num0 = 32'hFFFF_FFFF;
    step();
    step();
    chk("rst_op_ack", ack0, 1);
    step();
    step();
    chk("rst_op_calc2", {dp_ld, dp_mux_select}, 2'b10);
    rst = 0;
    step();
    chk("rst_op_idle", {busy, ack0, ack1, done0, done1, err, dp_ld, dp_ld_out, dp_mux_select}, 0);
    rst = 1;
    get_ack("rst_re", 1, 0, 32'hFFFF_FFFF);
    get_done("rst_re", 4, 0, 65535, 0, 0);
    req0 = 1; num0 = 32'hFFFF_FFFF;
    get_ack("late0", 2, 0, 32'hFFFF_FFFF);
    get_done("late0", 4, 0, 65535, 0, 1);
    get_ack("late1", 2, 1, 144);
    get_done("late1", 1, 1, 12, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
